// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine
// Self-sequenced ASCON permutation engine. One command applies p^a / p^b
// (6, 8 or 12 rounds) to either an external state or the chained internal
// state, with optional data / key / domain-separation XORs around the rounds.
// UNROLL_G rounds are evaluated per clock.
//
// Ports:
//   clock_i, resetb_i          clock, asynchronous active-low reset
//   start_i, rounds_i          command request and round count (6, 8, 12)
//   src_sel_i                  0: start from state_i, 1: from state_o (chaining)
//   state_i                    external state {S0,S1,S2,S3,S4}, S0 in the MSBs
//   data_i, en_xor_data_i      rate block XORed in before the first round
//   key_i                      key K, K[127:64] is the first key word
//   en_xor_key_begin_i         XOR K into the two capacity words after the rate
//   en_xor_key_end_i           XOR K into {S3,S4} after the last round
//   en_xor_lsb_i               S4[0] ^= 1 after the last round
//   ready_o, done_o, err_o     idle/done, one-cycle done pulse, illegal-rounds pulse
//   state_o, cipher_o, tag_o   state register, captured rate, captured {S3,S4}
//   fsm_state_o                current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a command is accepted on a rising edge where start_i && ready_o.
// start_i while RUN is ignored. done_o pulses for exactly one cycle once the
// result is in state_o/tag_o; a new command may be accepted in that cycle.

module ascon_perm_engine #(
    parameter int UNROLL_G = 1,
    parameter int RATE_G   = 64
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic [3:0]        rounds_i,
    input  logic              src_sel_i,
    input  logic [319:0]      state_i,
    input  logic [RATE_G-1:0] data_i,
    input  logic              en_xor_data_i,
    input  logic [127:0]      key_i,
    input  logic              en_xor_key_begin_i,
    input  logic              en_xor_key_end_i,
    input  logic              en_xor_lsb_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [319:0]      state_o,
    output logic [RATE_G-1:0] cipher_o,
    output logic [127:0]      tag_o,
    output logic [1:0]        fsm_state_o
);

    generate
        if (!(UNROLL_G == 1 || UNROLL_G == 2)) begin : g_bad_unroll
            $error("ascon_perm_engine: UNROLL_G must be 1 or 2");
        end
        if (!(RATE_G == 64 || RATE_G == 128)) begin : g_bad_rate
            $error("ascon_perm_engine: RATE_G must be 64 or 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One ASCON round: constant addition, bitsliced 5-bit S-box, linear layer.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2[7:0] = x2[7:0] ^ {4'hF - r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr64(x0, 19) ^ rotr64(x0, 28);
        x1 = x1 ^ rotr64(x1, 61) ^ rotr64(x1, 39);
        x2 = x2 ^ rotr64(x2, 1)  ^ rotr64(x2, 6);
        x3 = x3 ^ rotr64(x3, 10) ^ rotr64(x3, 17);
        x4 = x4 ^ rotr64(x4, 7)  ^ rotr64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    fsm_t              fsm_q, fsm_d;
    logic [319:0]      state_q, state_d;
    logic [RATE_G-1:0] cipher_q, cipher_d;
    logic [127:0]      tag_q, tag_d;
    logic [127:0]      key_q, key_d;
    logic [3:0]        round_q, round_d;   // index of the next round to run
    logic              ke_q, ke_d;
    logic              lsb_q, lsb_d;
    logic              err_q, err_d;

    logic [319:0] src_s, data_s, kb_s, rnd_in_s, rnd_out_s, fin_s;
    logic [3:0]   rnd_base;
    logic         legal, last_edge;

    // Pre-round XORs applied only on the accept edge.
    always_comb begin
        src_s  = src_sel_i ? state_q : state_i;
        data_s = src_s;
        data_s[319 -: RATE_G] = src_s[319 -: RATE_G] ^ (en_xor_data_i ? data_i : '0);
        kb_s = data_s;
        if (en_xor_key_begin_i) begin
            kb_s[319-RATE_G -: 128] = data_s[319-RATE_G -: 128] ^ key_i;
        end
    end

    // On the accept edge the rounds consume the freshly XORed source; in RUN
    // they consume the state register.
    assign rnd_in_s = (fsm_q == ST_RUN) ? state_q : kb_s;
    assign rnd_base = (fsm_q == ST_RUN) ? round_q : (4'd12 - rounds_i);

    always_comb begin
        rnd_out_s = rnd_in_s;
        for (int u = 0; u < UNROLL_G; u++) begin
            rnd_out_s = ascon_round(rnd_out_s, rnd_base + 4'(u));
        end
    end

    // Post-round XORs use the enables latched at acceptance.
    always_comb begin
        fin_s = rnd_out_s;
        if (ke_q) begin
            fin_s[127:0] = rnd_out_s[127:0] ^ key_q;
        end
        if (lsb_q) begin
            fin_s[0] = fin_s[0] ^ 1'b1;
        end
    end

    assign legal = ((rounds_i == 4'd6) || (rounds_i == 4'd8) || (rounds_i == 4'd12)) &&
                   ((rounds_i % 4'(UNROLL_G)) == 4'd0);
    // The accept edge always covers at least one round group, so with legal
    // round counts the last edge is always a RUN edge.
    assign last_edge = (round_q == 4'(12 - UNROLL_G));

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cipher_d = cipher_q;
        tag_d    = tag_q;
        key_d    = key_q;
        round_d  = round_q;
        ke_d     = ke_q;
        lsb_d    = lsb_q;
        err_d    = 1'b0;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                fsm_d = ST_IDLE;
                if (start_i) begin
                    if (legal) begin
                        fsm_d    = ST_RUN;
                        state_d  = rnd_out_s;
                        cipher_d = data_s[319 -: RATE_G];
                        key_d    = key_i;
                        ke_d     = en_xor_key_end_i;
                        lsb_d    = en_xor_lsb_i;
                        round_d  = 4'd12 - rounds_i + 4'(UNROLL_G);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                round_d = round_q + 4'(UNROLL_G);
                if (last_edge) begin
                    state_d = fin_s;
                    tag_d   = fin_s[127:0];
                    fsm_d   = ST_DONE;
                end else begin
                    state_d = rnd_out_s;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '0;
            cipher_q <= '0;
            tag_q    <= '0;
            key_q    <= '0;
            round_q  <= '0;
            ke_q     <= 1'b0;
            lsb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cipher_q <= cipher_d;
            tag_q    <= tag_d;
            key_q    <= key_d;
            round_q  <= round_d;
            ke_q     <= ke_d;
            lsb_q    <= lsb_d;
            err_q    <= err_d;
        end
    end

    assign ready_o     = (fsm_q != ST_RUN);
    assign done_o      = (fsm_q == ST_DONE);
    assign err_o       = err_q;
    assign state_o     = state_q;
    assign cipher_o    = cipher_q;
    assign tag_o       = tag_q;
    assign fsm_state_o = fsm_q;

endmodule
